// File: rtl/hwpe_ctrl_offloader.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_offloader
//
// Initiator-side driver for an HWPE control slave. A job descriptor (a set of
// IO register words) is accepted from a local sequencer. The block then
// programs the HWPE over its peripheral config port in this order:
//   1. read ACQUIRE until a free slot is returned (retrying after a back-off),
//   2. write every IO register in index order,
//   3. write TRIGGER,
//   4. poll STATUS, with a gap between polls, until it reads zero.
// The job ID returned by ACQUIRE is exported, and a one-cycle done pulse marks
// completion.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous abort; returns to IDLE
//   job_valid_i/job_ready_o  job descriptor handshake
//   job_regs_i               IO register words, word i at [32i+31:32i]
//   job_id_o                 ID from the last successful ACQUIRE
//   job_done_o               one-cycle completion pulse
//   busy_o                   high whenever a job is in progress
//   cfg_*                    config-port master (req/gnt, then r_valid)
// -----------------------------------------------------------------------------
module hwpe_ctrl_offloader #(
  parameter int unsigned N_JOB_REGS   = 8,
  parameter int unsigned ID_WIDTH     = 5,
  parameter int unsigned OFFLOADER_ID = 0,
  parameter int unsigned POLL_GAP     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [N_JOB_REGS*32-1:0] job_regs_i,
  output logic [7:0]               job_id_o,
  output logic                     job_done_o,
  output logic                     busy_o,
  output logic                     cfg_req_o,
  input  logic                     cfg_gnt_i,
  output logic [31:0]              cfg_add_o,
  output logic                     cfg_wen_o,
  output logic [3:0]               cfg_be_o,
  output logic [31:0]              cfg_data_o,
  output logic [ID_WIDTH-1:0]      cfg_id_o,
  input  logic                     cfg_r_valid_i,
  input  logic [31:0]              cfg_r_data_i
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
  localparam int unsigned IDX_W = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_JOB_REGS - 1);

  localparam logic [31:0] ADDR_TRIGGER = 32'h0000_0000;
  localparam logic [31:0] ADDR_ACQUIRE = 32'h0000_0004;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_000C;
  localparam logic [31:0] ADDR_IO_BASE = 32'h0000_0040;
  localparam logic [31:0] ACQ_FULL     = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ,
    ST_BACKOFF,
    ST_WR,
    ST_TRIG,
    ST_PWAIT,
    ST_POLL
  } state_e;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_nxt;
  logic             rsp_wait_q, rsp_wait_d;
  logic [7:0]       job_id_q, job_id_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic [31:0]      add_q, add_d;
  logic             wen_q, wen_d;
  logic [31:0]      data_q, data_d;
  logic             capture;
  logic             rsp_fire;

  // Job words are captured once per job and then only read; they need no reset.
  logic [31:0]      job_buf_q [N_JOB_REGS];

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    idx_d      = idx_q;
    rsp_wait_d = rsp_wait_q;
    job_id_d   = job_id_q;
    done_d     = 1'b0;
    req_d      = req_q;
    add_d      = add_q;
    wen_d      = wen_q;
    data_d     = data_q;
    capture    = 1'b0;
    idx_nxt    = idx_q + 1'b1;
    rsp_fire   = rsp_wait_q && cfg_r_valid_i;

    // Request leaves the port the cycle after its grant; from then on we only
    // wait for the response. Fields stay untouched while ungranted.
    if (req_q && cfg_gnt_i) begin
      req_d      = 1'b0;
      rsp_wait_d = 1'b1;
    end
    if (rsp_fire) begin
      rsp_wait_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (job_valid_i) begin
          capture = 1'b1;
          state_d = ST_ACQ;
          req_d   = 1'b1;
          add_d   = ADDR_ACQUIRE;
          wen_d   = 1'b1;
          data_d  = '0;
        end
      end

      ST_ACQ: begin
        if (rsp_fire) begin
          if (cfg_r_data_i == ACQ_FULL) begin
            state_d = ST_BACKOFF;
            gap_d   = '0;
          end else begin
            job_id_d = cfg_r_data_i[7:0];
            idx_d    = '0;
            state_d  = ST_WR;
            req_d    = 1'b1;
            add_d    = ADDR_IO_BASE;
            wen_d    = 1'b0;
            data_d   = job_buf_q[0];
          end
        end
      end

      ST_BACKOFF: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_ACQ;
          req_d   = 1'b1;
          add_d   = ADDR_ACQUIRE;
          wen_d   = 1'b1;
          data_d  = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_WR: begin
        if (rsp_fire) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_TRIG;
            req_d   = 1'b1;
            add_d   = ADDR_TRIGGER;
            wen_d   = 1'b0;
            data_d  = '0;
          end else begin
            idx_d  = idx_nxt;
            req_d  = 1'b1;
            add_d  = ADDR_IO_BASE + (32'(idx_nxt) << 2);
            wen_d  = 1'b0;
            data_d = job_buf_q[idx_nxt];
          end
        end
      end

      ST_TRIG: begin
        if (rsp_fire) begin
          state_d = ST_PWAIT;
          gap_d   = '0;
        end
      end

      ST_PWAIT: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_POLL;
          req_d   = 1'b1;
          add_d   = ADDR_STATUS;
          wen_d   = 1'b1;
          data_d  = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_POLL: begin
        if (rsp_fire) begin
          if (cfg_r_data_i == 32'h0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PWAIT;
            gap_d   = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a job offered in the same cycle.
    // The job ID is intentionally kept.
    if (clear_i) begin
      state_d    = ST_IDLE;
      gap_d      = '0;
      idx_d      = '0;
      rsp_wait_d = 1'b0;
      req_d      = 1'b0;
      done_d     = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      idx_q      <= '0;
      rsp_wait_q <= 1'b0;
      job_id_q   <= '0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      add_q      <= '0;
      wen_q      <= 1'b1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      rsp_wait_q <= rsp_wait_d;
      job_id_q   <= job_id_d;
      done_q     <= done_d;
      req_q      <= req_d;
      add_q      <= add_d;
      wen_q      <= wen_d;
      data_q     <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      for (int i = 0; i < N_JOB_REGS; i++) begin
        job_buf_q[i] <= job_regs_i[32*i +: 32];
      end
    end
  end

  // In IDLE the done pulse and job_ready coincide, allowing back-to-back jobs.
  assign job_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign job_id_o    = job_id_q;
  assign job_done_o  = done_q;
  assign cfg_req_o   = req_q;
  assign cfg_add_o   = add_q;
  assign cfg_wen_o   = wen_q;
  assign cfg_be_o    = 4'hF;
  assign cfg_data_o  = data_q;
  assign cfg_id_o    = ID_WIDTH'(OFFLOADER_ID);

endmodule

// File: tb/tb_hwpe_ctrl_offloader.sv
// -----------------------------------------------------------------------------
// tb_hwpe_ctrl_offloader
//
// Bench for hwpe_ctrl_offloader. A behavioural HWPE slave grants requests
// after a random or forced stall, answers one cycle or more after the grant,
// and logs every granted transaction. The expected transaction list of each
// job is built from the job description (ACQUIRE replies, job words, STATUS
// replies) and compared with the log once the job completes.
// -----------------------------------------------------------------------------
module tb_hwpe_ctrl_offloader;

  localparam int N   = 8;
  localparam int GAP = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] data;
  } txn_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear;
  logic           job_valid;
  logic           job_ready;
  logic [N*32-1:0] job_regs;
  logic [7:0]     job_id;
  logic           job_done;
  logic           busy;
  logic           cfg_req;
  logic           cfg_gnt;
  logic [31:0]    cfg_add;
  logic           cfg_wen;
  logic [3:0]     cfg_be;
  logic [31:0]    cfg_data;
  logic [4:0]     cfg_id;
  logic           cfg_r_valid;
  logic [31:0]    cfg_r_data;

  always #5 clk = ~clk;

  hwpe_ctrl_offloader #(
    .N_JOB_REGS  (N),
    .ID_WIDTH    (5),
    .OFFLOADER_ID(0),
    .POLL_GAP    (GAP)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .job_valid_i  (job_valid),
    .job_ready_o  (job_ready),
    .job_regs_i   (job_regs),
    .job_id_o     (job_id),
    .job_done_o   (job_done),
    .busy_o       (busy),
    .cfg_req_o    (cfg_req),
    .cfg_gnt_i    (cfg_gnt),
    .cfg_add_o    (cfg_add),
    .cfg_wen_o    (cfg_wen),
    .cfg_be_o     (cfg_be),
    .cfg_data_o   (cfg_data),
    .cfg_id_o     (cfg_id),
    .cfg_r_valid_i(cfg_r_valid),
    .cfg_r_data_i (cfg_r_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
    txn_t t;
    t.addr = a;
    t.wen  = w;
    t.data = d;
    return t;
  endfunction

  // Slave scripting and logging
  txn_t        exp_q [$];
  txn_t        log_q [$];
  logic [31:0] acq_q [$];
  logic [31:0] stat_q[$];
  int          max_stall  = 0;
  int          max_rdly   = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_len  = 0;
  int          stall_seen = 0;
  bit          inject     = 1'b0;
  int          cyc        = 0;
  int          done_cnt   = 0;

  initial begin : slave
    bit          tracking;
    bit          pend;
    int          stall_left;
    int          rdly;
    int          req_cycles;
    int          last_acq_gnt;
    int          last_stat_gnt;
    logic [31:0] rval;
    txn_t        cur;
    tracking      = 1'b0;
    pend          = 1'b0;
    stall_left    = 0;
    rdly          = 0;
    req_cycles    = 0;
    rval          = '0;
    cur           = '0;
    last_acq_gnt  = -1000000;
    last_stat_gnt = -1000000;
    cfg_gnt       = 1'b0;
    cfg_r_valid   = 1'b0;
    cfg_r_data    = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      cfg_gnt     = 1'b0;
      cfg_r_valid = 1'b0;
      if (inject) begin
        cfg_r_valid = 1'b1;
        cfg_r_data  = 32'h0;
        inject      = 1'b0;
      end else if (pend) begin
        if (rdly == 0) begin
          cfg_r_valid = 1'b1;
          cfg_r_data  = rval;
          pend        = 1'b0;
        end else begin
          rdly--;
        end
      end
      if (!cfg_req) begin
        tracking = 1'b0;
      end else begin
        if (!tracking) begin
          tracking   = 1'b1;
          req_cycles = 0;
          cur        = mk(cfg_add, cfg_wen, cfg_wen ? 32'h0 : cfg_data);
          stall_left = (cfg_add == stall_addr) ? stall_len : int'($urandom_range(max_stall, 0));
          if (cfg_wen && cfg_add == 32'h4)
            chk("acq_retry_gap", 96'((cyc - last_acq_gnt) >= GAP), 96'(1));
          if (cfg_wen && cfg_add == 32'hC)
            chk("poll_gap", 96'((cyc - last_stat_gnt) >= GAP), 96'(1));
        end else begin
          chk("req_stable", 96'(mk(cfg_add, cfg_wen, cfg_wen ? 32'h0 : cfg_data)), 96'(cur));
        end
        req_cycles++;
        if (stall_left == 0) begin
          cfg_gnt  = 1'b1;
          tracking = 1'b0;
          log_q.push_back(cur);
          pend = 1'b1;
          rdly = int'($urandom_range(max_rdly, 0));
          rval = 32'h0;
          if (cur.wen && cur.addr == 32'h4) begin
            if (acq_q.size() > 0) rval = acq_q.pop_front();
            last_acq_gnt = cyc;
          end
          if (cur.wen && cur.addr == 32'hC) begin
            if (stat_q.size() > 0) rval = stat_q.pop_front();
            last_stat_gnt = cyc;
          end
          if (cur.addr == stall_addr) stall_seen = req_cycles;
        end else begin
          stall_left--;
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (job_done) done_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Expected transactions of one job, straight from the programming sequence.
  task automatic plan_job(input logic [N*32-1:0] words, input int n_full,
                          input logic [31:0] id_word, input int n_busy,
                          input logic [31:0] busy_word);
    for (int i = 0; i < n_full; i++) begin
      acq_q.push_back(32'hFFFF_FFFF);
      exp_q.push_back(mk(32'h4, 1'b1, 32'h0));
    end
    acq_q.push_back(id_word);
    exp_q.push_back(mk(32'h4, 1'b1, 32'h0));
    for (int i = 0; i < N; i++)
      exp_q.push_back(mk(32'h40 + 32'(4 * i), 1'b0, words[32*i +: 32]));
    exp_q.push_back(mk(32'h0, 1'b0, 32'h0));
    for (int i = 0; i < n_busy; i++) begin
      stat_q.push_back(busy_word);
      exp_q.push_back(mk(32'hC, 1'b1, 32'h0));
    end
    stat_q.push_back(32'h0);
    exp_q.push_back(mk(32'hC, 1'b1, 32'h0));
  endtask

  function automatic logic [N*32-1:0] rand_words();
    logic [N*32-1:0] w;
    for (int i = 0; i < N; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (job_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic compare_log(input string tag);
    int n;
    chk({tag, "_n_txn"}, 96'(log_q.size()), 96'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_txn%0d", tag, i), 96'(log_q[i]), 96'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
    acq_q.delete();
    stat_q.delete();
  endtask

  task automatic run_job(input string tag, input int n_full, input logic [31:0] id_word,
                         input int n_busy, input logic [31:0] busy_word);
    logic [N*32-1:0] w;
    int d0;
    bit ok;
    w  = rand_words();
    d0 = done_cnt;
    plan_job(w, n_full, id_word, n_busy, busy_word);
    @(posedge clk); #1;
    chk({tag, "_ready_before"}, 96'(job_ready), 96'(1));
    job_regs  = w;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    wait_done(3000, ok);
    chk({tag, "_done_seen"}, 96'(ok), 96'(1));
    chk({tag, "_busy_at_done"}, 96'(busy), 96'(0));
    chk({tag, "_ready_at_done"}, 96'(job_ready), 96'(1));
    chk({tag, "_job_id"}, 96'(job_id), 96'(id_word[7:0]));
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 96'(done_cnt - d0), 96'(1));
    compare_log(tag);
  endtask

  initial begin : main
    logic [N*32-1:0] wa, wb;
    logic [31:0]     ida, idb;
    int              d0, k, reqs;
    bit              ok;
    rst_n     = 1'b0;
    clear     = 1'b0;
    job_valid = 1'b0;
    job_regs  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 96'(job_ready), 96'(1));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(job_done), 96'(0));
    chk("rst_job_id", 96'(job_id), 96'(0));
    chk("rst_req", 96'(cfg_req), 96'(0));
    chk("rst_add", 96'(cfg_add), 96'(0));
    chk("rst_wen", 96'(cfg_wen), 96'(1));
    chk("rst_data", 96'(cfg_data), 96'(0));
    chk("rst_be", 96'(cfg_be), 96'(4'hF));
    chk("rst_cfg_id", 96'(cfg_id), 96'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic job: zero-wait grant, response at grant+1, STATUS busy twice
    max_stall = 0;
    max_rdly  = 0;
    run_job("basic", 0, 32'd3, 2, 32'd1);

    // ACQUIRE full twice before success
    run_job("acq_full", 2, 32'd0, 0, 32'd1);

    // Five-cycle grant stall on IO write 2
    stall_addr = 32'h48;
    stall_len  = 5;
    stall_seen = 0;
    run_job("stall", 0, 32'h1234_5607, 1, 32'h8000_0000);
    chk("stall_req_cycles", 96'(stall_seen), 96'(6));
    stall_addr = 32'hFFFF_FFFF;

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      logic [31:0] id_r;
      max_stall = int'($urandom_range(3, 0));
      max_rdly  = int'($urandom_range(2, 0));
      id_r = $urandom;
      if (id_r == 32'hFFFF_FFFF) id_r = 32'h0;
      run_job($sformatf("rand%0d", j), int'($urandom_range(2, 0)), id_r,
              int'($urandom_range(3, 0)), $urandom | 32'h1);
    end
    max_stall = 0;
    max_rdly  = 0;

    // Clear while IO write 4 is ungranted
    wa  = rand_words();
    ida = 32'h0000_00A5;
    d0  = done_cnt;
    acq_q.push_back(ida);
    exp_q.push_back(mk(32'h4, 1'b1, 32'h0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'h40 + 32'(4 * i), 1'b0, wa[32*i +: 32]));
    stall_addr = 32'h50;
    stall_len  = 100000;
    @(posedge clk); #1;
    job_regs  = wa;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cfg_req && cfg_add == 32'h50) begin
        ok = 1'b1;
        break;
      end
    end
    chk("clr_reached_wr4", 96'(ok), 96'(1));
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clr_req", 96'(cfg_req), 96'(0));
    chk("clr_busy", 96'(busy), 96'(0));
    chk("clr_ready", 96'(job_ready), 96'(1));
    repeat (40) @(negedge clk);
    chk("clr_job_id_kept", 96'(job_id), 96'(8'hA5));
    chk("clr_no_done", 96'(done_cnt - d0), 96'(0));
    compare_log("clr");
    stall_addr = 32'hFFFF_FFFF;

    // Clear beats a job offered in the same cycle
    @(posedge clk); #1;
    job_valid = 1'b1;
    clear     = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    clear     = 1'b0;
    @(negedge clk);
    chk("clr_prio_busy", 96'(busy), 96'(0));
    chk("clr_prio_req", 96'(cfg_req), 96'(0));

    // Back-to-back jobs with job_valid held high
    wa  = rand_words();
    wb  = rand_words();
    ida = 32'h0000_0011;
    idb = 32'h0000_0022;
    d0  = done_cnt;
    plan_job(wa, 0, ida, 1, 32'h2);
    plan_job(wb, 1, idb, 0, 32'h2);
    @(posedge clk); #1;
    job_regs  = wa;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_regs = wb;
    wait_done(3000, ok);
    chk("b2b_done_a", 96'(ok), 96'(1));
    chk("b2b_id_a", 96'(job_id), 96'(8'h11));
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      k++;
      if (cfg_req && cfg_add == 32'h4) break;
    end
    chk("b2b_acq_latency_ok", 96'(k <= 2), 96'(1));
    job_valid = 1'b0;
    wait_done(3000, ok);
    chk("b2b_done_b", 96'(ok), 96'(1));
    chk("b2b_id_b", 96'(job_id), 96'(8'h22));
    repeat (3) @(negedge clk);
    chk("b2b_done_pulses", 96'(done_cnt - d0), 96'(2));
    compare_log("b2b");

    // Asynchronous reset during the STATUS poll wait
    wa = rand_words();
    d0 = done_cnt;
    plan_job(wa, 0, 32'h0000_0077, 3, 32'h5);
    @(posedge clk); #1;
    job_regs  = wa;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (log_q.size() > 0 && log_q[log_q.size()-1].addr == 32'hC) begin
        ok = 1'b1;
        break;
      end
    end
    chk("arst_reached_poll", 96'(ok), 96'(1));
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 96'(cfg_req), 96'(0));
    chk("arst_busy", 96'(busy), 96'(0));
    chk("arst_ready", 96'(job_ready), 96'(1));
    chk("arst_job_id", 96'(job_id), 96'(0));
    chk("arst_add", 96'(cfg_add), 96'(0));
    chk("arst_wen", 96'(cfg_wen), 96'(1));
    chk("arst_data", 96'(cfg_data), 96'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    log_q.delete();
    exp_q.delete();
    acq_q.delete();
    stat_q.delete();
    inject = 1'b1;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_req || busy) reqs++;
    end
    chk("arst_stray_ignored", 96'(reqs), 96'(0));
    chk("arst_no_done", 96'(done_cnt - d0), 96'(0));
    chk("arst_no_txn", 96'(log_q.size()), 96'(0));

    // Recovery after reset
    max_stall = 2;
    max_rdly  = 1;
    run_job("after_rst", 1, 32'h0000_0009, 1, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
